// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 core: one-hot instruction type
// codes, the LSU state encoding and the default LSU bus timeout.
package ysyx_25020047_pkg;

  localparam logic [31:0] INST_LW  = 32'h0000_0020;
  localparam logic [31:0] INST_LBU = 32'h0000_0040;
  localparam logic [31:0] INST_SW  = 32'h0000_0080;
  localparam logic [31:0] INST_SB  = 32'h0000_0100;
  localparam logic [31:0] INST_SH  = 32'h0020_0000;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic for the LSU: store byte steering, load byte
// extraction with zero extension, and misalignment detection.
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [31:0] i_instType,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_rspRdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_loadData,
  output logic        o_misaligned
);

  logic [7:0] w_loadByte;

  always_comb begin
    w_loadByte = i_rspRdata[7:0];
    case (i_addr[1:0])
      2'd1:    w_loadByte = i_rspRdata[15:8];
      2'd2:    w_loadByte = i_rspRdata[23:16];
      2'd3:    w_loadByte = i_rspRdata[31:24];
      default: w_loadByte = i_rspRdata[7:0];
    endcase
  end

  // Sub-word stores replicate their data across every lane so the mask alone
  // selects which bytes the memory actually updates.
  always_comb begin
    o_wdata      = i_storeData;
    o_wmask      = 4'b0000;
    o_loadData   = i_rspRdata;
    o_misaligned = 1'b0;
    case (i_instType)
      INST_LW: o_misaligned = |i_addr[1:0];
      INST_LBU: o_loadData = {24'b0, w_loadByte};
      INST_SW: begin
        o_misaligned = |i_addr[1:0];
        o_wmask      = 4'b1111;
      end
      INST_SH: begin
        o_misaligned = i_addr[0];
        o_wmask      = 4'b0011 << i_addr[1:0];
        o_wdata      = {2{i_storeData[15:0]}};
      end
      INST_SB: begin
        o_wmask = 4'b0001 << i_addr[1:0];
        o_wdata = {4{i_storeData[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one EXU record at a time, runs a request/response
// data-bus transaction for memory ops, and presents a registered WBU record.
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_type,
  input  logic [31:0] result,
  input  logic [31:0] rdata2,
  input  logic        reg_wen,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wdata,
  output logic        out_reg_wen,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e  r_state, w_stateNext;
  logic [CW-1:0] r_count, w_countNext;
  logic [31:0] r_instType, w_instTypeNext;
  logic [31:0] r_addr, w_addrNext;
  logic        r_isStore, w_isStoreNext;
  logic        r_memReqValid, w_memReqValidNext;
  logic        r_memWen, w_memWenNext;
  logic [31:0] r_memAddr, w_memAddrNext;
  logic [31:0] r_memWdata, w_memWdataNext;
  logic [3:0]  r_memWmask, w_memWmaskNext;
  logic        r_outValid, w_outValidNext;
  logic [31:0] r_outWdata, w_outWdataNext;
  logic        r_outRegWen, w_outRegWenNext;
  logic [4:0]  r_outRd, w_outRdNext;
  logic        r_outErr, w_outErrNext;

  logic [31:0] w_alignType, w_alignAddr, w_wdata, w_loadData;
  logic [3:0]  w_wmask;
  logic        w_misaligned, w_expire;

  // In IDLE the lane logic looks at the incoming record; afterwards it looks at
  // the latched one so the load byte is picked from the accepted address.
  assign w_alignType = (r_state == LSU_IDLE) ? inst_type : r_instType;
  assign w_alignAddr = (r_state == LSU_IDLE) ? result : r_addr;

  ysyx_25020047_lsu_align u_align (
    .i_instType  (w_alignType),
    .i_addr      (w_alignAddr),
    .i_storeData (rdata2),
    .i_rspRdata  (mem_rsp_rdata),
    .o_wdata     (w_wdata),
    .o_wmask     (w_wmask),
    .o_loadData  (w_loadData),
    .o_misaligned(w_misaligned)
  );

  assign w_expire = ({1'b0, r_count} + {{CW{1'b0}}, 1'b1}) >= (CW + 1)'(TIMEOUT);

  // A handshake or response seen in the last allowed cycle still wins over the
  // abort; the counter saturates so it cannot wrap while waiting.
  always_comb begin
    w_stateNext       = r_state;
    w_countNext       = r_count;
    w_instTypeNext    = r_instType;
    w_addrNext        = r_addr;
    w_isStoreNext     = r_isStore;
    w_memReqValidNext = r_memReqValid;
    w_memWenNext      = r_memWen;
    w_memAddrNext     = r_memAddr;
    w_memWdataNext    = r_memWdata;
    w_memWmaskNext    = r_memWmask;
    w_outValidNext    = r_outValid;
    w_outWdataNext    = r_outWdata;
    w_outRegWenNext   = r_outRegWen;
    w_outRdNext       = r_outRd;
    w_outErrNext      = r_outErr;
    if (r_state == LSU_REQ || r_state == LSU_WAIT)
      w_countNext = (r_count == CW'(TIMEOUT)) ? r_count : r_count + 1'b1;
    unique case (r_state)
      LSU_IDLE: begin
        if (in_valid) begin
          w_instTypeNext = inst_type;
          w_addrNext     = result;
          w_isStoreNext  = write;
          w_outRdNext    = in_rd;
          w_countNext    = '0;
          if (!read && !write) begin
            w_stateNext     = LSU_RESP;
            w_outValidNext  = 1'b1;
            w_outWdataNext  = result;
            w_outRegWenNext = reg_wen;
            w_outErrNext    = 1'b0;
          end else if ((read && write) || w_misaligned) begin
            w_stateNext     = LSU_RESP;
            w_outValidNext  = 1'b1;
            w_outWdataNext  = result;
            w_outRegWenNext = 1'b0;
            w_outErrNext    = 1'b1;
          end else begin
            w_stateNext       = LSU_REQ;
            w_memReqValidNext = 1'b1;
            w_memWenNext      = write;
            w_memAddrNext     = {result[31:2], 2'b00};
            w_memWdataNext    = write ? w_wdata : 32'h0;
            w_memWmaskNext    = write ? w_wmask : 4'b0000;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          w_stateNext       = LSU_WAIT;
          w_memReqValidNext = 1'b0;
        end else if (w_expire) begin
          w_stateNext       = LSU_RESP;
          w_memReqValidNext = 1'b0;
          w_outValidNext    = 1'b1;
          w_outWdataNext    = r_addr;
          w_outRegWenNext   = 1'b0;
          w_outErrNext      = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (mem_rsp_valid) begin
          w_stateNext     = LSU_RESP;
          w_outValidNext  = 1'b1;
          w_outErrNext    = 1'b0;
          w_outWdataNext  = r_isStore ? r_addr : w_loadData;
          w_outRegWenNext = !r_isStore;
        end else if (w_expire) begin
          w_stateNext     = LSU_RESP;
          w_outValidNext  = 1'b1;
          w_outWdataNext  = r_addr;
          w_outRegWenNext = 1'b0;
          w_outErrNext    = 1'b1;
        end
      end
      LSU_RESP: begin
        if (out_ready) begin
          w_stateNext    = LSU_IDLE;
          w_outValidNext = 1'b0;
        end
      end
      default: w_stateNext = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= LSU_IDLE;
      r_count       <= '0;
      r_instType    <= '0;
      r_addr        <= '0;
      r_isStore     <= 1'b0;
      r_memReqValid <= 1'b0;
      r_memWen      <= 1'b0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_memWmask    <= '0;
      r_outValid    <= 1'b0;
      r_outWdata    <= '0;
      r_outRegWen   <= 1'b0;
      r_outRd       <= '0;
      r_outErr      <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_count       <= w_countNext;
      r_instType    <= w_instTypeNext;
      r_addr        <= w_addrNext;
      r_isStore     <= w_isStoreNext;
      r_memReqValid <= w_memReqValidNext;
      r_memWen      <= w_memWenNext;
      r_memAddr     <= w_memAddrNext;
      r_memWdata    <= w_memWdataNext;
      r_memWmask    <= w_memWmaskNext;
      r_outValid    <= w_outValidNext;
      r_outWdata    <= w_outWdataNext;
      r_outRegWen   <= w_outRegWenNext;
      r_outRd       <= w_outRdNext;
      r_outErr      <= w_outErrNext;
    end
  end

  assign in_ready      = (r_state == LSU_IDLE);
  assign mem_req_valid = r_memReqValid;
  assign mem_wen       = r_memWen;
  assign mem_addr      = r_memAddr;
  assign mem_wdata     = r_memWdata;
  assign mem_wmask     = r_memWmask;
  assign out_valid     = r_outValid;
  assign out_wdata     = r_outWdata;
  assign out_reg_wen   = r_outRegWen;
  assign out_rd        = r_outRd;
  assign out_err       = r_outErr;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed plus randomized bench for the LSU; expectations come from a
// behavioural model of each transaction computed with plain arithmetic.
module tb_ysyx_25020047_lsu;
  import ysyx_25020047_pkg::*;

  localparam int TMO = 4;
  localparam int K_PASS = 0, K_LW = 1, K_LBU = 2, K_SW = 3, K_SH = 4, K_SB = 5, K_BOTH = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] inst_type = '0, result = '0, rdata2 = '0;
  logic        reg_wen = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        out_valid, out_ready = 1'b0, out_reg_wen, out_err;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  int txnId  = 0;

  ysyx_25020047_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .result(result), .rdata2(rdata2),
    .reg_wen(reg_wen), .read(read), .write(write), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
    .out_reg_wen(out_reg_wen), .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL txn%0d %s observed=0x%08h expected=0x%08h",
             txnId, tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete record: offer it, play the bus with the given delays, check
  // the writeback record, then hold it for holdCycles before accepting it.
  task automatic applyStimulus(input int kind, input logic [31:0] addr,
                               input logic [31:0] data2, input logic [31:0] rspData,
                               input logic wen, input logic [4:0] rd,
                               input int reqDelay, input int rspDelay, input int holdCycles);
    logic [31:0] itype, expBusData, expOut;
    logic [3:0]  expMask;
    logic        rdS, wrS, bad, isStore, expRegWen;
    int          off;
    txnId++;
    off = int'(addr % 4);
    rdS = 1'b0; wrS = 1'b0; itype = 32'h0000_0001;
    case (kind)
      K_LW:    begin itype = INST_LW;  rdS = 1'b1; end
      K_LBU:   begin itype = INST_LBU; rdS = 1'b1; end
      K_SW:    begin itype = INST_SW;  wrS = 1'b1; end
      K_SH:    begin itype = INST_SH;  wrS = 1'b1; end
      K_SB:    begin itype = INST_SB;  wrS = 1'b1; end
      K_BOTH:  begin itype = INST_LW;  rdS = 1'b1; wrS = 1'b1; end
      default: ;
    endcase
    isStore = wrS && !rdS;
    bad = (rdS && wrS) || ((kind == K_LW || kind == K_SW) && off != 0) ||
          (kind == K_SH && (off % 2) != 0);
    expMask = 4'b0000; expBusData = 32'h0;
    if (kind == K_SW) begin expMask = 4'hF; expBusData = data2; end
    if (kind == K_SH) begin expMask = 4'(3 << off); expBusData = (data2 & 32'hFFFF) * 32'h0001_0001; end
    if (kind == K_SB) begin expMask = 4'(1 << off); expBusData = (data2 & 32'hFF) * 32'h0101_0101; end
    expOut = addr;
    if (kind == K_LW)  expOut = rspData;
    if (kind == K_LBU) expOut = (rspData >> (8 * off)) & 32'hFF;
    expRegWen = (kind == K_PASS) ? wen : (bad ? 1'b0 : !isStore);

    checkOutput("inReadyIdle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; inst_type = itype; result = addr; rdata2 = data2;
    reg_wen = wen; read = rdS; write = wrS; in_rd = rd;
    step();
    in_valid = 1'b0; inst_type = $urandom; result = $urandom; rdata2 = $urandom;
    reg_wen = 1'b0; read = 1'b0; write = 1'b0; in_rd = 5'($urandom);
    checkOutput("inReadyBusy", {31'b0, in_ready}, 32'd0);
    if (kind == K_PASS || bad) begin
      checkOutput("noReq", {31'b0, mem_req_valid}, 32'd0);
    end else begin
      checkOutput("reqValid", {31'b0, mem_req_valid}, 32'd1);
      checkOutput("memAddr", mem_addr, addr & 32'hFFFF_FFFC);
      checkOutput("memWen", {31'b0, mem_wen}, {31'b0, isStore});
      checkOutput("memWmask", {28'b0, mem_wmask}, {28'b0, expMask});
      if (isStore) checkOutput("memWdata", mem_wdata, expBusData);
      for (int i = 0; i < reqDelay; i++) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
        step();
      end
      checkOutput("reqHeld", {31'b0, mem_req_valid}, 32'd1);
      checkOutput("addrHeld", mem_addr, addr & 32'hFFFF_FFFC);
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = ~rspData;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      checkOutput("reqDropped", {31'b0, mem_req_valid}, 32'd0);
      checkOutput("noEarlyOut", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < rspDelay; i++) step();
      mem_rsp_valid = 1'b1; mem_rsp_rdata = rspData;
      step();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
    end
    checkOutput("outValid", {31'b0, out_valid}, 32'd1);
    checkOutput("outErr", {31'b0, out_err}, {31'b0, bad});
    checkOutput("outRegWen", {31'b0, out_reg_wen}, {31'b0, expRegWen});
    checkOutput("outRd", {27'b0, out_rd}, {27'b0, rd});
    if (!bad) checkOutput("outWdata", out_wdata, expOut);
    out_ready = 1'b0;
    for (int i = 0; i < holdCycles; i++) step();
    if (holdCycles > 0) begin
      checkOutput("outValidHeld", {31'b0, out_valid}, 32'd1);
      checkOutput("outRdHeld", {27'b0, out_rd}, {27'b0, rd});
      if (!bad) checkOutput("outWdataHeld", out_wdata, expOut);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("outConsumed", {31'b0, out_valid}, 32'd0);
    checkOutput("inReadyAgain", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    int kind;

    #3;
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstReqValid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    checkOutput("rstOutWdata", out_wdata, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    step();

    $display("[TB] directed transactions");
    applyStimulus(K_PASS, 32'h0000_0005, 32'h0, 32'h0, 1'b1, 5'd10, 0, 0, 0);
    applyStimulus(K_LBU, 32'h8000_0003, 32'h0, 32'hAB12_3456, 1'b0, 5'd11, 0, 0, 0);
    applyStimulus(K_SH, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0, 1, 1, 1);
    applyStimulus(K_LW, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 5'd12, 0, 0, 0);
    applyStimulus(K_LW, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0, 5'd13, 0, 0, 2);
    applyStimulus(K_SB, 32'h8000_0001, 32'h0000_00C3, 32'h0, 1'b0, 5'd1, 0, 0, 0);

    // Bus never accepts: abort after TMO cycles in REQ.
    txnId++;
    in_valid = 1'b1; inst_type = INST_SW; result = 32'h8000_0010; rdata2 = 32'h1234_5678;
    read = 1'b0; write = 1'b1; reg_wen = 1'b1; in_rd = 5'd7;
    step();
    in_valid = 1'b0; write = 1'b0; reg_wen = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      checkOutput("tmoReqHeld", {31'b0, mem_req_valid}, 32'd1);
      step();
    end
    checkOutput("tmoReqLast", {31'b0, mem_req_valid}, 32'd1);
    step();
    checkOutput("tmoReqDrop", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("tmoOutValid", {31'b0, out_valid}, 32'd1);
    checkOutput("tmoErr", {31'b0, out_err}, 32'd1);
    checkOutput("tmoRegWen", {31'b0, out_reg_wen}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    checkOutput("tmoHeldValid", {31'b0, out_valid}, 32'd1);
    checkOutput("tmoHeldErr", {31'b0, out_err}, 32'd1);
    checkOutput("tmoHeldRd", {27'b0, out_rd}, 32'd7);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checkOutput("tmoConsumed", {31'b0, out_valid}, 32'd0);

    // Reset in WAIT abandons the load immediately.
    txnId++;
    in_valid = 1'b1; inst_type = INST_LW; result = 32'h8000_0020; read = 1'b1; in_rd = 5'd9;
    step();
    in_valid = 1'b0; read = 1'b0;
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    checkOutput("waitNoOut", {31'b0, out_valid}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstWaitOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstWaitMemAddr", mem_addr, 32'd0);
    checkOutput("rstWaitMemWmask", {28'b0, mem_wmask}, 32'd0);
    checkOutput("rstWaitOutRd", {27'b0, out_rd}, 32'd0);
    checkOutput("rstWaitInReady", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("strayRspIgnored", {31'b0, out_valid}, 32'd0);
    checkOutput("strayRspIdle", {31'b0, in_ready}, 32'd1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 6);
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0 && (kind == K_LW || kind == K_SW)) addr[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0 && kind == K_SH) addr[0] = 1'b0;
      applyStimulus(kind, addr, $urandom, $urandom, 1'($urandom), 5'($urandom),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
